// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: N:1 multi-bit mux (N = 2**SEL_W) built as a binary tree of 2:1 levels.
// Level l pairs the level l-1 results (2j, 2j+1) under sel[l]: sel bit 0 picks the even input,
// sel bit 1 picks the odd input. A register stage with valid/ready flow control can be placed
// after any level (PIPE_MASK bit l). The select travels with the data, so a new select can be
// accepted every cycle.
//
// Ports:
//   clk        in   1            rising-edge clock
//   rst_n      in   1            asynchronous active-low reset
//   in_valid   in   1            in_data / in_sel valid
//   in_ready   out  1            input accepted this cycle
//   in_data    in   N*DATA_W     word i = in_data[i*DATA_W +: DATA_W]
//   in_sel     in   SEL_W        index of the word to forward
//   out_valid  out  1            out_data valid
//   out_ready  in   1            sink accepts out_data
//   out_data   out  DATA_W       selected word
//   out_sel    out  SEL_W        select carried with the result
module mux_tree_pipe #(
  parameter int unsigned      DATA_W    = 8,
  parameter int unsigned      SEL_W     = 3,
  parameter logic [SEL_W-1:0] PIPE_MASK = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [(1 << SEL_W)*DATA_W-1:0]   in_data,
  input  logic [SEL_W-1:0]                 in_sel,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_W-1:0]                out_data,
  output logic [SEL_W-1:0]                 out_sel
);

  localparam int N = 1 << SEL_W;

  for (genvar l = 0; l < SEL_W; l++) begin : g_lvl
    localparam int NIn  = N >> l;
    localparam int NOut = N >> (l + 1);

    logic [DATA_W-1:0] w_d_in  [NIn];
    logic [SEL_W-1:0]  w_s_in;
    logic              w_v_in;
    logic              w_rdy_in;   // ready presented to the previous level
    logic [DATA_W-1:0] w_mux   [NOut];
    logic [DATA_W-1:0] w_d_out [NOut];
    logic [SEL_W-1:0]  w_s_out;
    logic              w_v_out;
    logic              w_rdy_out;  // ready seen from the next level

    // Hook up to the input ports or to the previous level.
    if (l == 0) begin : g_src
      for (genvar i = 0; i < N; i++) begin : g_word
        assign w_d_in[i] = in_data[i*DATA_W +: DATA_W];
      end
      assign w_s_in   = in_sel;
      assign w_v_in   = in_valid;
      assign in_ready = w_rdy_in;
    end else begin : g_chain
      for (genvar i = 0; i < NIn; i++) begin : g_word
        assign w_d_in[i] = g_lvl[l-1].w_d_out[i];
      end
      assign w_s_in = g_lvl[l-1].w_s_out;
      assign w_v_in = g_lvl[l-1].w_v_out;
    end

    if (l == SEL_W - 1) begin : g_sink
      assign w_rdy_out = out_ready;
    end else begin : g_next
      assign w_rdy_out = g_lvl[l+1].w_rdy_in;
    end

    for (genvar j = 0; j < NOut; j++) begin : g_mux2
      assign w_mux[j] = w_s_in[l] ? w_d_in[2*j+1] : w_d_in[2*j];
    end

    if (PIPE_MASK[l]) begin : g_reg
      logic              r_v;
      logic [DATA_W-1:0] r_d [NOut];
      logic [SEL_W-1:0]  r_s;
      logic              w_en;

      // Bubble-collapsing: an empty stage always accepts.
      assign w_en = ~r_v | w_rdy_out;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v <= 1'b0;
          r_s <= '0;
          for (int j = 0; j < NOut; j++) r_d[j] <= '0;
        end else if (w_en) begin
          r_v <= w_v_in;
          // Payload only loads on a real word so bubbles do not toggle the datapath.
          if (w_v_in) begin
            r_s <= w_s_in;
            for (int j = 0; j < NOut; j++) r_d[j] <= w_mux[j];
          end
        end
      end

      assign w_rdy_in = w_en;
      assign w_v_out  = r_v;
      assign w_s_out  = r_s;
      for (genvar j = 0; j < NOut; j++) begin : g_out
        assign w_d_out[j] = r_d[j];
      end
    end else begin : g_comb
      assign w_rdy_in = w_rdy_out;
      assign w_v_out  = w_v_in;
      assign w_s_out  = w_s_in;
      for (genvar j = 0; j < NOut; j++) begin : g_out
        assign w_d_out[j] = w_mux[j];
      end
    end
  end

  assign out_valid = g_lvl[SEL_W-1].w_v_out;
  assign out_data  = g_lvl[SEL_W-1].w_d_out[0];
  assign out_sel   = g_lvl[SEL_W-1].w_s_out;

endmodule

// File: tb/tb_mux_tree_pipe.sv
module tb_mux_tree_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Combinational instance: DATA_W=1, PIPE_MASK=0
  logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [7:0] c_in_data;
  logic [2:0] c_in_sel, c_out_sel;
  logic [0:0] c_out_data;

  mux_tree_pipe #(.DATA_W(1), .SEL_W(3), .PIPE_MASK(3'b000)) u_comb (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_sel(c_in_sel), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .out_sel(c_out_sel)
  );

  // Fully pipelined instance: PIPE_MASK=3'b111
  logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready;
  logic [63:0] p_in_data;
  logic [2:0]  p_in_sel, p_out_sel;
  logic [7:0]  p_out_data;

  mux_tree_pipe #(.DATA_W(8), .SEL_W(3), .PIPE_MASK(3'b111)) u_pipe (
    .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .in_data(p_in_data), .in_sel(p_in_sel), .out_valid(p_out_valid),
    .out_ready(p_out_ready), .out_data(p_out_data), .out_sel(p_out_sel)
  );

  // Middle-stage instance: PIPE_MASK=3'b010
  logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready;
  logic [63:0] m_in_data;
  logic [2:0]  m_in_sel, m_out_sel;
  logic [7:0]  m_out_data;

  mux_tree_pipe #(.DATA_W(8), .SEL_W(3), .PIPE_MASK(3'b010)) u_mid (
    .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_data(m_in_data), .in_sel(m_in_sel), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .out_data(m_out_data), .out_sel(m_out_sel)
  );

  // Scoreboards: expected word pushed on input handshake, popped on output handshake.
  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] data;
  } sb_t;

  sb_t        q_p[$];
  sb_t        q_m[$];
  int         p_pops = 0;
  logic [7:0] p_last_data = 8'h00;

  always @(negedge clk) begin
    sb_t it;
    if (rst_n) begin
      if (p_in_valid && p_in_ready) begin
        it.sel  = p_in_sel;
        it.data = p_in_data[p_in_sel*8 +: 8];
        q_p.push_back(it);
      end
      if (p_out_valid && p_out_ready) begin
        if (q_p.size() == 0) begin
          check("p_unexpected_out", 1, 0);
        end else begin
          it = q_p.pop_front();
          check("p_out_data", {24'h0, p_out_data}, {24'h0, it.data});
          check("p_out_sel", {29'h0, p_out_sel}, {29'h0, it.sel});
          p_last_data = it.data;
          p_pops++;
        end
      end
      if (m_in_valid && m_in_ready) begin
        it.sel  = m_in_sel;
        it.data = m_in_data[m_in_sel*8 +: 8];
        q_m.push_back(it);
      end
      if (m_out_valid && m_out_ready) begin
        if (q_m.size() == 0) begin
          check("m_unexpected_out", 1, 0);
        end else begin
          it = q_m.pop_front();
          check("m_out_data", {24'h0, m_out_data}, {24'h0, it.data});
          check("m_out_sel", {29'h0, m_out_sel}, {29'h0, it.sel});
        end
      end
    end
  end

  // Drive one word and hold it until accepted (bounded).
  task automatic send(input bit which, input logic [2:0] sel, input logic [63:0] data);
    int n;
    n = 0;
    if (which) begin
      m_in_valid = 1'b1; m_in_sel = sel; m_in_data = data;
    end else begin
      p_in_valid = 1'b1; p_in_sel = sel; p_in_data = data;
    end
    @(negedge clk);
    while (!(which ? m_in_ready : p_in_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (which) m_in_valid = 1'b0;
    else       p_in_valid = 1'b0;
  endtask

  // Count cycles until out_valid rises (bounded).
  task automatic wait_valid(input bit which, output int n);
    n = 0;
    while (!(which ? m_out_valid : p_out_valid) && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
  endtask

  function automatic logic [63:0] stream_word(input int k);
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(k*16 + i);
    return d;
  endfunction

  typedef struct {
    logic [7:0] data;
    logic [2:0] sel;
    logic       rdy;
    logic       vld;
    logic       exp_d;
    logic       exp_rdy;
    logic       exp_vld;
  } cvec_t;

  cvec_t       ctab[8];
  int          lat;
  logic [7:0]  hold_d;
  logic [2:0]  hold_s;
  logic [7:0]  dv;
  logic [63:0] wd;
  int          pop_base;
  logic        ov_exp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ctab[0] = '{8'h01, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ctab[1] = '{8'h80, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ctab[2] = '{8'h7F, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ctab[3] = '{8'hA5, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ctab[4] = '{8'hA5, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ctab[5] = '{8'h5A, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    ctab[6] = '{8'hFE, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ctab[7] = '{8'h10, 3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0;
    c_in_valid = 1'b0; c_in_data = '0; c_in_sel = '0; c_out_ready = 1'b1;
    p_in_valid = 1'b0; p_in_data = '0; p_in_sel = '0; p_out_ready = 1'b1;
    m_in_valid = 1'b0; m_in_data = '0; m_in_sel = '0; m_out_ready = 1'b1;
    #23;
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", p_out_valid, 0);
    check("rst_out_data", {24'h0, p_out_data}, 0);
    check("rst_out_sel", {29'h0, p_out_sel}, 0);
    check("rst_in_ready", p_in_ready, 1);
    check("rst_m_out_valid", m_out_valid, 0);

    // Combinational instance: directed table, then all data x select combinations.
    for (int i = 0; i < 8; i++) begin
      c_in_data = ctab[i].data; c_in_sel = ctab[i].sel;
      c_out_ready = ctab[i].rdy; c_in_valid = ctab[i].vld;
      #1;
      check("comb_tab_data", c_out_data, ctab[i].exp_d);
      check("comb_tab_in_ready", c_in_ready, ctab[i].exp_rdy);
      check("comb_tab_out_valid", c_out_valid, ctab[i].exp_vld);
      check("comb_tab_out_sel", {29'h0, c_out_sel}, {29'h0, ctab[i].sel});
    end
    c_out_ready = 1'b1; c_in_valid = 1'b1;
    for (int di = 0; di < 256; di++) begin
      for (int s = 0; s < 8; s++) begin
        dv = 8'(di);
        c_in_data = dv; c_in_sel = 3'(s);
        #1;
        check("comb_data", c_out_data, dv[s]);
      end
    end
    check("comb_in_ready", c_in_ready, 1);

    // Full pipeline: words 0x10..0x17, sel 0..7 back to back.
    @(posedge clk); #1;
    fork
      begin
        for (int k = 0; k < 8; k++) send(1'b0, 3'(k), 64'h1716151413121110);
      end
      begin
        wait_valid(1'b0, lat);
        check("t2_latency", lat, 3);
        for (int k = 1; k < 8; k++) begin
          @(posedge clk); #2;
          check("t2_streaming_valid", p_out_valid, 1);
        end
      end
    join
    repeat (5) @(posedge clk);
    #1;
    check("t2_drained", q_p.size(), 0);

    // Middle-stage pipeline: single word, latency 1.
    for (int i = 0; i < 8; i++) wd[i*8 +: 8] = 8'(8'h30 + i);
    wd[5*8 +: 8] = 8'hA5;
    fork
      send(1'b1, 3'd5, wd);
      begin
        wait_valid(1'b1, lat);
        check("t3_latency", lat, 1);
        check("t3_data", {24'h0, m_out_data}, 32'hA5);
        check("t3_sel", {29'h0, m_out_sel}, 5);
      end
    join
    repeat (2) @(posedge clk);
    #2;
    check("t3_single_word", m_out_valid, 0);

    // Stream of 10 words with a 4-cycle output stall.
    pop_base = p_pops;
    fork
      begin
        for (int k = 0; k < 10; k++) send(1'b0, 3'((k*3) % 8), stream_word(k));
      end
      begin
        repeat (5) @(posedge clk);
        #2;
        p_out_ready = 1'b0;
        @(negedge clk);
        check("t4_stall_valid", p_out_valid, 1);
        hold_d = (q_p.size() > 0) ? q_p[0].data : 8'hxx;
        hold_s = (q_p.size() > 0) ? q_p[0].sel : 3'bxxx;
        repeat (3) begin
          @(negedge clk);
          check("t4_hold_data", {24'h0, p_out_data}, {24'h0, hold_d});
          check("t4_hold_sel", {29'h0, p_out_sel}, {29'h0, hold_s});
        end
        check("t4_in_ready_low", p_in_ready, 0);
        @(posedge clk);
        #2;
        p_out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    check("t4_all_emitted", p_pops - pop_base, 10);
    check("t4_queue_empty", q_p.size(), 0);

    // Bubble pattern 1,0,1,0,1,0 with garbage on bubble slots.
    for (int t = 0; t < 12; t++) begin
      @(posedge clk); #1;
      ov_exp = (t >= 3) && (t < 9) && ((t - 3) % 2 == 0);
      check("t5_out_valid", p_out_valid, ov_exp);
      if (t >= 4 && !ov_exp) check("t5_hold", {24'h0, p_out_data}, {24'h0, p_last_data});
      if (t < 6 && (t % 2 == 0)) begin
        for (int i = 0; i < 8; i++) wd[i*8 +: 8] = 8'(8'h40 + t*8 + i);
        p_in_valid = 1'b1; p_in_sel = 3'(t + 1); p_in_data = wd;
      end else begin
        p_in_valid = 1'b0; p_in_sel = 3'(7 - t % 8); p_in_data = '1;
      end
    end
    p_in_valid = 1'b0;

    // Reset mid-stream with 3 words in flight.
    p_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(1'b0, 3'(k + 2), stream_word(k + 11));
    @(posedge clk); #3;
    rst_n = 1'b0;
    q_p.delete();
    #1;
    check("t6_rst_out_valid", p_out_valid, 0);
    check("t6_rst_out_data", {24'h0, p_out_data}, 0);
    check("t6_rst_out_sel", {29'h0, p_out_sel}, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    p_out_ready = 1'b1;
    #1;
    check("t6_in_ready", p_in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #2;
      check("t6_no_stale", p_out_valid, 0);
    end
    @(posedge clk); #1;
    fork
      send(1'b0, 3'd6, stream_word(14));
      begin
        wait_valid(1'b0, lat);
        check("t6_latency", lat, 3);
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("final_p_empty", q_p.size(), 0);
    check("final_m_empty", q_m.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
